wash_sequencer: RTL and testbench

Runs the paid wash programme after the billing stage has charged the customer. It latches the selected mode on billing's one-cycle `next` pulse and steps through wash, rinse and spin phases, counting each phase down in whole seconds. It drives motor and valve enables, a phase/status light bus and four digit codes for the shared `scan4` display scanner. It reports `busy` back to billing so billing can block new charges while a programme runs.

---
 rtl/wash_sequencer_pkg.sv | 23 ++
 rtl/wash_sequencer_if.sv | 12 +
 rtl/wash_sequencer_bcd_down3.sv | 25 ++
 rtl/wash_sequencer.sv | 61 ++++++
 tb/tb_wash_sequencer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/wash_sequencer_pkg.sv
// wash_sequencer_pkg: shared state/mode encodings, light patterns and BCD phase durations
package wash_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, WASH, RINSE, SPIN, DONE} state_t;
  typedef enum logic [1:0] {MODE_DRY, MODE_SMALL, MODE_MEDIUM, MODE_LARGE} mode_t;
  localparam logic [3:0] BLANK = 4'd11;
  localparam logic [7:0] LIGHT_IDLE = 8'b0000_0001;
  localparam logic [7:0] LIGHT_WASH = 8'b0000_0010;
  localparam logic [7:0] LIGHT_RINSE = 8'b0000_0100;
  localparam logic [7:0] LIGHT_SPIN = 8'b0000_1000;
  localparam logic [7:0] LIGHT_DONE = 8'b0001_0000;
  localparam logic [7:0] LIGHT_PAUSE = 8'b1000_0000;
  // Indexed by mode: dry, small, medium, large (lowest slice first)
  localparam logic [3:0][11:0] WASH_DUR = {12'h120, 12'h090, 12'h060, 12'h000};
  localparam logic [3:0][11:0] RINSE_DUR = {12'h060, 12'h045, 12'h030, 12'h000};
  localparam logic [3:0][11:0] SPIN_DUR = {12'h060, 12'h045, 12'h030, 12'h030};
  function automatic logic [11:0] phase_dur(mode_t m, state_t s);
    return s == WASH ? WASH_DUR[m] : s == RINSE ? RINSE_DUR[m] : SPIN_DUR[m];
  endfunction
  function automatic logic [7:0] state_light(state_t s);
    return s == WASH ? LIGHT_WASH : s == RINSE ? LIGHT_RINSE : s == SPIN ? LIGHT_SPIN :
           s == DONE ? LIGHT_DONE : LIGHT_IDLE;
  endfunction
endpackage

// File: rtl/wash_sequencer_if.sv
// wash_sequencer_if: control inputs from billing/panel and status/display outputs of the sequencer
interface wash_sequencer_if;
  logic on, start, pause;
  logic [1:0] mode;
  logic busy, done, motor, valve;
  logic [7:0] st_light;
  logic [3:0] d3, d2, d1, d0;
  modport master (output on, start, mode, pause,
                  input busy, done, motor, valve, st_light, d3, d2, d1, d0);
  modport slave (input on, start, mode, pause,
                 output busy, done, motor, valve, st_light, d3, d2, d1, d0);
endinterface

// File: rtl/wash_sequencer_bcd_down3.sv
// bcd_down3: 3-digit BCD down counter with load, decrement enable and count==001 flag
module bcd_down3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        dec,
  input  logic [11:0] val,
  output logic [11:0] q,
  output logic        is_one
);
  logic b0, b1;
  logic [3:0] d0n, d1n, d2n;
  always_comb begin
    b0 = q[3:0] == 4'd0;
    b1 = b0 && q[7:4] == 4'd0;
    d0n = b0 ? 4'd9 : q[3:0] - 4'd1;
    d1n = !b0 ? q[7:4] : b1 ? 4'd9 : q[7:4] - 4'd1;
    d2n = !b1 ? q[11:8] : q[11:8] == 4'd0 ? 4'd9 : q[11:8] - 4'd1;
  end
  assign is_one = q == 12'h001;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (load) q <= val;
    else if (dec) q <= {d2n, d1n, d0n};
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: paid wash programme FSM with per-second BCD countdown and display/light decode
module wash_sequencer
  import wash_sequencer_pkg::*;
#(
  parameter int TICK_CYCLES = 100_000_000
) (
  input logic clk,
  input logic rst,
  wash_sequencer_if.slave bus
);
  localparam int CW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  state_t state, nxt, first;
  mode_t mode_q;
  logic paused, busy, go, run, tick, load, dec, is_one;
  logic [CW-1:0] cnt;
  logic [11:0] val, rem;
  always_comb begin
    busy = state == WASH || state == RINSE || state == SPIN;
    go = bus.start && !busy;
    run = busy && !bus.pause;
    tick = run && cnt == CW'(TICK_CYCLES - 1);
    nxt = state == WASH ? RINSE : state == RINSE ? SPIN : DONE;
    first = bus.mode == MODE_DRY ? SPIN : WASH;
    load = !bus.on || go || (tick && is_one);
    dec = bus.on && tick && !is_one;
    val = !bus.on ? 12'h000 : go ? phase_dur(mode_t'(bus.mode), first) : phase_dur(mode_q, nxt);
  end
  bcd_down3 u_cnt (
    .clk(clk), .rst(rst), .load(load), .dec(dec), .val(val), .q(rem), .is_one(is_one)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      mode_q <= MODE_DRY;
      paused <= 1'b0;
      cnt <= '0;
    end else if (!bus.on) begin
      state <= IDLE;
      mode_q <= MODE_DRY;
      paused <= 1'b0;
      cnt <= '0;
    end else begin
      paused <= bus.pause;
      if (go) begin
        state <= first;
        mode_q <= mode_t'(bus.mode);
        cnt <= '0;
      end else if (run) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick && is_one) state <= nxt;
      end
    end
  assign bus.busy = busy;
  assign bus.done = state == DONE;
  assign bus.motor = (state == WASH || state == SPIN) && !paused;
  assign bus.valve = state == RINSE && !paused;
  assign bus.st_light = state_light(state) | (busy && paused ? LIGHT_PAUSE : 8'h00);
  assign bus.d3 = state == IDLE ? BLANK : state == WASH ? 4'd1 : state == RINSE ? 4'd2 :
                  state == SPIN ? 4'd3 : 4'd0;
  assign {bus.d2, bus.d1, bus.d0} = state == IDLE ? {3{BLANK}} : state == DONE ? 12'h000 : rem;
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed and random stimulus checked against a seconds-level programme model
module tb_wash_sequencer;
  localparam int T = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  wash_sequencer_if sif ();
  wash_sequencer #(.TICK_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(sif));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 wash, 2 rinse, 3 spin, 4 done; seconds left as a plain integer
  int dur_tab [4][3] = '{'{0, 0, 30}, '{60, 30, 30}, '{90, 45, 45}, '{120, 60, 60}};
  int ph = 0, rem = 0, sub = 0, m = 0;
  bit mp = 0;
  int q_ph[$], q_sec[$];
  always @(posedge clk) begin
    if (!rst || !sif.on) begin
      ph = 0; rem = 0; sub = 0; mp = 0;
      q_ph.delete(); q_sec.delete();
    end else begin
      if ((ph == 0 || ph == 4) && sif.start) begin
        q_ph.delete(); q_sec.delete();
        m = int'(sif.mode);
        for (int p = 0; p < 3; p++)
          if (dur_tab[m][p] > 0) begin q_ph.push_back(p + 1); q_sec.push_back(dur_tab[m][p]); end
        ph = q_ph.pop_front(); rem = q_sec.pop_front(); sub = 0;
      end else if (ph >= 1 && ph <= 3 && !sif.pause) begin
        sub++;
        if (sub == T) begin
          sub = 0; rem--;
          if (rem == 0) begin
            if (q_ph.size() == 0) ph = 4;
            else begin ph = q_ph.pop_front(); rem = q_sec.pop_front(); end
          end
        end
      end
      mp = sif.pause;
    end
  end

  always @(posedge clk) begin
    #1;
    begin
      bit b;
      b = ph >= 1 && ph <= 3;
      chk("m_busy", int'(sif.busy), int'(b));
      chk("m_done", int'(sif.done), int'(ph == 4));
      chk("m_motor", int'(sif.motor), int'((ph == 1 || ph == 3) && !mp));
      chk("m_valve", int'(sif.valve), int'(ph == 2 && !mp));
      chk("m_light", int'(sif.st_light), (1 << ph) | ((b && mp) ? 128 : 0));
      chk("m_d3", int'(sif.d3), ph == 0 ? 11 : ph == 4 ? 0 : ph);
      chk("m_d2", int'(sif.d2), ph == 0 ? 11 : ph == 4 ? 0 : rem / 100);
      chk("m_d1", int'(sif.d1), ph == 0 ? 11 : ph == 4 ? 0 : (rem / 10) % 10);
      chk("m_d0", int'(sif.d0), ph == 0 ? 11 : ph == 4 ? 0 : rem % 10);
    end
  end

  task automatic lit(input string nm, input int e3, e2, e1, e0, el, eb, ed, em);
    chk({nm, "_d3"}, int'(sif.d3), e3);
    chk({nm, "_d2"}, int'(sif.d2), e2);
    chk({nm, "_d1"}, int'(sif.d1), e1);
    chk({nm, "_d0"}, int'(sif.d0), e0);
    chk({nm, "_light"}, int'(sif.st_light), el);
    chk({nm, "_busy"}, int'(sif.busy), eb);
    chk({nm, "_done"}, int'(sif.done), ed);
    chk({nm, "_motor"}, int'(sif.motor), em);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int md);
    sif.start = 1'b1;
    sif.mode = 2'(md);
    step(1);
    sif.start = 1'b0;
  endtask

  initial begin
    sif.on = 1'b1; sif.start = 1'b0; sif.mode = 2'd0; sif.pause = 1'b0;
    step(3);
    rst = 1'b1;
    step(50);
    lit("idle", 11, 11, 11, 11, 1, 0, 0, 0);
    pulse_start(0);
    lit("dry_start", 3, 0, 3, 0, 8, 1, 0, 1);
    step(299);
    lit("dry_last", 3, 0, 0, 1, 8, 1, 0, 1);
    step(1);
    lit("dry_done", 0, 0, 0, 0, 16, 0, 1, 0);
    pulse_start(3);
    lit("lg_start", 1, 1, 2, 0, 2, 1, 0, 1);
    step(10);
    lit("lg_119", 1, 1, 1, 9, 2, 1, 0, 1);
    step(1189);
    lit("lg_wash_last", 1, 0, 0, 1, 2, 1, 0, 1);
    step(1);
    lit("lg_rinse", 2, 0, 6, 0, 4, 1, 0, 0);
    chk("lg_valve", int'(sif.valve), 1);
    step(600);
    lit("lg_spin", 3, 0, 6, 0, 8, 1, 0, 1);
    step(600);
    lit("lg_done", 0, 0, 0, 0, 16, 0, 1, 0);
    pulse_start(1);
    step(155);
    lit("sm_045", 1, 0, 4, 5, 2, 1, 0, 1);
    sif.pause = 1'b1;
    step(1);
    lit("sm_pause", 1, 0, 4, 5, 130, 1, 0, 0);
    step(36);
    lit("sm_pause_end", 1, 0, 4, 5, 130, 1, 0, 0);
    sif.pause = 1'b0;
    step(1044);
    lit("sm_last", 3, 0, 0, 1, 8, 1, 0, 1);
    step(1);
    lit("sm_done", 0, 0, 0, 0, 16, 0, 1, 0);
    pulse_start(2);
    step(1000);
    lit("md_rinse", 2, 0, 3, 5, 4, 1, 0, 0);
    sif.mode = 2'd0;
    sif.start = 1'b1;
    step(1);
    sif.start = 1'b0;
    lit("md_ignore", 2, 0, 3, 5, 4, 1, 0, 0);
    sif.on = 1'b0;
    step(1);
    lit("md_off", 11, 11, 11, 11, 1, 0, 0, 0);
    sif.start = 1'b1;
    sif.mode = 2'd1;
    step(1);
    sif.start = 1'b0;
    sif.on = 1'b1;
    lit("off_start", 11, 11, 11, 11, 1, 0, 0, 0);
    step(5);
    lit("off_start_lost", 11, 11, 11, 11, 1, 0, 0, 0);
    pulse_start(0);
    step(100);
    #2 rst = 1'b0;
    #1 lit("rst_async", 11, 11, 11, 11, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(2);
    lit("rst_after", 11, 11, 11, 11, 1, 0, 0, 0);
    for (int i = 0; i < 6000; i++) begin
      sif.start = $urandom_range(0, 39) == 0;
      sif.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) sif.pause = ~sif.pause;
      sif.on = $urandom_range(0, 399) != 0;
      step(1);
    end
    sif.start = 1'b0;
    sif.on = 1'b1;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
